divider32by16_seq: RTL
======================

// Module: divider32by16_seq
// PURPOSE
//  Iterative restoring divider; the inverse of the 16x16->32 multiplier datapath.
//  Divides a 2*W-bit dividend (a multiplier product) by a W-bit divisor, one quotient bit/cycle.
//  Sits beside the approximate multipliers as the exact reference for error analysis: P/B -> A.
//  Valid/ready handshakes on both sides; one division in flight at a time.
// PARAMETERS
//  W      16   divisor, quotient and remainder width; dividend is 2*W bits
//  CNT_W  5    iteration counter width, $clog2(W)+1
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     async, active-high reset
//  in_valid    in   1     dividend/divisor valid
//  in_ready    out  1     block can accept a new operation
//  dividend    in   2*W   numerator (unsigned)
//  divisor     in   W     denominator (unsigned)
//  out_valid   out  1     result valid; held until out_ready
//  out_ready   in   1     downstream accepts result
//  quotient    out  W     unsigned quotient
//  remainder   out  W     unsigned remainder
//  div_by_zero out  1     divisor was 0
//  overflow    out  1     quotient does not fit W bits (dividend[2W-1:W] >= divisor, divisor!=0)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0,
//   div_by_zero=0, overflow=0, counter=0. Reset mid-CALC drops the operation; no result emitted.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready capture operands (registered), flags evaluated:
//   divisor==0          -> div_by_zero=1, quotient=all-ones, remainder=dividend[W-1:0], go DONE.
//   dividend[2W-1:W]>=divisor -> overflow=1, quotient=all-ones, remainder=all-ones, go DONE.
//   else partial rem R=dividend[2W-1:W], shift reg Q=dividend[W-1:0], counter=W, go CALC.
//  CALC: in_ready=0. Each cycle: T={R,Q[W-1]} (W+1 bits); if T>=divisor R=T-divisor, Qbit=1
//   else R=T[W-1:0], Qbit=0; Q={Q[W-2:0],Qbit}; counter--. After W iterations (counter==1
//   on last) go DONE with quotient=Q, remainder=R, flags 0.
//  DONE: out_valid=1, in_ready=0; outputs stable while out_valid&&!out_ready.
//   On out_ready: out_valid=0 next cycle, go IDLE. No combinational ready->valid paths.
//  Latency: accept at edge N -> out_valid high from edge N+W+1 (normal);
//   N+1 for div_by_zero/overflow. Throughput: one op per W+2 cycles minimum.
//  in_valid while busy is ignored (in_ready=0); source must hold data until accepted.
//  Arithmetic: all unsigned; subtraction in W+1 bits so no carry loss at R=2^W-1.
//  Invariant on normal completion: quotient*divisor+remainder==dividend, remainder<divisor.
// TESTING
//  1. dividend=0x0000_0064, divisor=0x0007 -> after 17 cycles q=0x000E, r=0x0002, flags 0.
//  2. dividend=0x0626_0060 (0x1234*0x5678), divisor=0x5678 -> q=0x1234, r=0x0000.
//  3. divisor=0x0000, dividend=0xABCD_1234 -> next cycle out_valid, div_by_zero=1,
//     q=0xFFFF, r=0x1234.
//  4. dividend=0x0005_0000, divisor=0x0005 -> overflow=1, q=0xFFFF, r=0xFFFF, latency 1.
//  5. dividend=0xFFFE_0001, divisor=0xFFFF -> q=0xFFFF, r=0x0000; hold out_ready=0 for 5
//     cycles -> outputs stable, in_ready=0; in_valid pulses during CALC/DONE ignored.
//  6. Assert rst at CALC iteration 8 -> all outputs reset immediately, in_ready=1; next op
//     (1000/10) -> q=100, r=0. Plus 10k random ops checked against invariant.

Source files
------------

// File: rtl/divider32by16_seq.sv
// divider32by16_seq: iterative restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per cycle
module divider32by16_seq #(
  parameter int W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [W-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [W:0] t, diff;
  logic ge;
  // quotient/remainder double as the shift register and partial remainder while in CALC
  always_comb begin
    t = {remainder, quotient[W-1]};
    diff = t - {1'b0, dvs};
    ge = t >= {1'b0, dvs};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
      cnt <= '0;
      dvs <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          in_ready <= 1'b0;
          dvs <= divisor;
          div_by_zero <= divisor == '0;
          overflow <= divisor != '0 && dividend[2*W-1:W] >= divisor;
          cnt <= CNT_W'(W);
          quotient <= divisor == '0 || dividend[2*W-1:W] >= divisor ? '1 : dividend[W-1:0];
          remainder <= divisor == '0 ? dividend[W-1:0] : dividend[2*W-1:W] >= divisor ? '1 : dividend[2*W-1:W];
          state <= divisor == '0 || dividend[2*W-1:W] >= divisor ? DONE : CALC;
        end
        CALC: begin
          remainder <= ge ? diff[W-1:0] : t[W-1:0];
          quotient <= {quotient[W-2:0], ge};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, so no ready->valid path exists
          if (!out_valid) out_valid <= 1'b1;
          else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
